mips_main_fsm: RTL and testbench
================================

Name: mips_main_fsm

Overview:
- State sequencer for the multicycle MIPS datapath.
- Holds the 4-bit state register and walks each instruction through fetch, decode, execute, memory and writeback states.
- Waits on the memory handshake and halts on an illegal opcode.
- Feeds its state to the downstream control decoder, which produces the datapath select and ALU signals; this block also drives the write strobes and a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, cycles spent waiting on mem_ready before a timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- funct  input  6  IR[5:0]; used only to flag an illegal R-type.
- zero  input  1  ALU zero flag; sampled in BRANCH.
- mem_ready  input  1  memory has completed the current read or write.
- state  output  4  current state (encoding below).
- pc_write  output  1  PC load strobe.
- ir_write  output  1  IR load strobe.
- reg_write  output  1  register file write strobe.
- mem_wr_ena  output  1  data memory write strobe.
- mem_req  output  1  memory access request.
- halted  output  1  in HALT.
- timeout  output  1  sticky flag: a memory wait exceeded MEM_TIMEOUT.
- instr_count  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- State encoding:
  - FETCH=0, READ_FROM_MEMORY=1, DECODE=2, EXECUTE=3, ALU_WRITEBACK=4
  - MEM_ADDR=5, MEM_READ=6, MEM_WRITEBACK=7, MEM_WRITE=8
  - BRANCH=9, JUMP=10, IMM_EXECUTE=11, HALT=15
  - Codes 12-14 are unused; if reached, the next state is HALT.
- Reset (async, rst=1): state=FETCH; instr_count=0; timeout=0. All strobes follow the state decode, so pc_write=1 while in reset.
- Strobes are Moore-decoded from state, except where gated by mem_ready:
  - pc_write=1 in FETCH, in JUMP, and in BRANCH when taken.
  - mem_req=1 in READ_FROM_MEMORY, MEM_READ and MEM_WRITE.
  - ir_write = (state==READ_FROM_MEMORY) & mem_ready.
  - mem_wr_ena = (state==MEM_WRITE) & mem_ready.
  - reg_write=1 in ALU_WRITEBACK and MEM_WRITEBACK.
  - halted=1 in HALT.
- Transitions:
  - FETCH -> READ_FROM_MEMORY.
  - READ_FROM_MEMORY -> DECODE when mem_ready; otherwise stay.
  - DECODE on opcode:
    - 0x00 -> EXECUTE.
    - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
    - 0x04 (beq) or 0x05 (bne) -> BRANCH.
    - 0x02 (j) -> JUMP.
    - 0x08 (addi) -> IMM_EXECUTE.
    - Any other opcode -> HALT.
  - R-type with funct[5]==0 goes to HALT from DECODE.
  - EXECUTE and IMM_EXECUTE -> ALU_WRITEBACK -> FETCH.
  - MEM_ADDR -> MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ -> MEM_WRITEBACK when mem_ready; otherwise stay.
  - MEM_WRITEBACK -> FETCH.
  - MEM_WRITE -> FETCH when mem_ready; otherwise stay.
  - BRANCH and JUMP -> FETCH.
  - HALT -> HALT; only rst exits it.
- Branch taken:
  - beq: zero==1.
  - bne: zero==0.
  - Taken is decoded combinationally in BRANCH.
- Memory timeout:
  - A wait counter clears on entering any wait state and increments each cycle mem_ready=0 in that state.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is HALT and timeout is set.
  - timeout stays set until rst.
  - mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT completes normally; completion has priority.
- instr_count:
  - Increments by 1 at each edge where the current state is ALU_WRITEBACK, MEM_WRITEBACK, BRANCH or JUMP, or is MEM_WRITE with mem_ready=1.
  - Wraps modulo 2^COUNT_WIDTH.
  - Does not change in HALT.
- rst asserted mid-instruction:
  - Outputs take reset values immediately, without waiting for a clock.
  - Any pending memory wait is abandoned.

Test Plan:
- Reset, release, hold mem_ready=1, opcode=0x00, funct=0x20 -> states 0,1,2,3,4,0; ir_write high in state 1; reg_write high in state 4; instr_count=1.
- lw (0x23) with mem_ready low for 3 cycles in MEM_READ -> state sequence 0,1,2,5,6,6,6,6,7,0; exactly one reg_write cycle; instr_count increments once.
- sw (0x2B) -> mem_wr_ena high only on the MEM_WRITE cycle with mem_ready=1; no reg_write; instr_count increments.
- beq with zero=1 -> pc_write high in state 9. bne with zero=1 -> pc_write low in state 9. Both return to FETCH.
- opcode=0x3F -> HALT (15) after DECODE, halted=1, instr_count frozen; pulse rst -> state=0 asynchronously, count=0.
- mem_ready held 0 in READ_FROM_MEMORY -> after 15 waiting cycles, state=15 and timeout=1. Repeat with mem_ready=1 on the 15th cycle -> DECODE, timeout=0.

Source files
------------

// File: rtl/mips_main_fsm.sv
// mips_main_fsm: state sequencer for the multicycle MIPS datapath
//   clk, rst          : clock and asynchronous active-high reset
//   opcode_i, funct_i : IR[31:26] and IR[5:0]
//   zero_i            : ALU zero flag, used in BRANCH
//   mem_ready_i       : memory read/write completion
//   state_o           : current state code for the control decoder
//   pc_write_o, ir_write_o, reg_write_o, mem_wr_ena_o, mem_req_o : datapath strobes
//   halted_o, timeout_o : in HALT, sticky memory-wait timeout
//   instr_count_o     : retired-instruction counter
module mips_main_fsm #(
   parameter int COUNT_WIDTH = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             opcode_i,
   input  logic [5:0]             funct_i,
   input  logic                   zero_i,
   input  logic                   mem_ready_i,
   output logic [3:0]             state_o,
   output logic                   pc_write_o,
   output logic                   ir_write_o,
   output logic                   reg_write_o,
   output logic                   mem_wr_ena_o,
   output logic                   mem_req_o,
   output logic                   halted_o,
   output logic                   timeout_o,
   output logic [COUNT_WIDTH-1:0] instr_count_o
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [3:0] {
      FETCH         = 4'd0,
      READ_MEM      = 4'd1,
      DECODE        = 4'd2,
      EXECUTE       = 4'd3,
      ALU_WB        = 4'd4,
      MEM_ADDR      = 4'd5,
      MEM_READ      = 4'd6,
      MEM_WB        = 4'd7,
      MEM_WRITE     = 4'd8,
      BRANCH        = 4'd9,
      JUMP          = 4'd10,
      IMM_EXECUTE   = 4'd11,
      HALT          = 4'd15
   } state_t;
   state_t                 state_q, state_d;
   logic [WW-1:0]          wait_q, wait_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   timeout_q, timeout_d;
   logic                   waiting, expired, taken, retire, unused_funct;
   assign unused_funct = ^funct_i[4:0];
   assign waiting = (state_q == READ_MEM) | (state_q == MEM_READ) | (state_q == MEM_WRITE);
   // wait_q holds the not-ready cycles already spent, so this is the MEM_TIMEOUT-th one
   assign expired = waiting & ~mem_ready_i & (wait_q == WW'(MEM_TIMEOUT - 1));
   assign taken   = (opcode_i == 6'h04) ? zero_i : ~zero_i;
   assign retire  = (state_q == ALU_WB) | (state_q == MEM_WB) | (state_q == BRANCH) |
                    (state_q == JUMP) | ((state_q == MEM_WRITE) & mem_ready_i);
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:                  state_d = READ_MEM;
         READ_MEM:               state_d = mem_ready_i ? DECODE : READ_MEM;
         DECODE:
            case (opcode_i)
               6'h00:            state_d = funct_i[5] ? EXECUTE : HALT;
               6'h23, 6'h2B:     state_d = MEM_ADDR;
               6'h04, 6'h05:     state_d = BRANCH;
               6'h02:            state_d = JUMP;
               6'h08:            state_d = IMM_EXECUTE;
               default:          state_d = HALT;
            endcase
         EXECUTE, IMM_EXECUTE:   state_d = ALU_WB;
         ALU_WB, MEM_WB:         state_d = FETCH;
         BRANCH, JUMP:           state_d = FETCH;
         MEM_ADDR:               state_d = (opcode_i == 6'h23) ? MEM_READ : MEM_WRITE;
         MEM_READ:               state_d = mem_ready_i ? MEM_WB : MEM_READ;
         MEM_WRITE:              state_d = mem_ready_i ? FETCH : MEM_WRITE;
         default:                state_d = HALT;
      endcase
      if (expired) state_d = HALT;
   end
   // any cycle outside a not-ready wait leaves the counter at zero for the next wait
   assign wait_d    = (waiting & ~mem_ready_i & ~expired) ? wait_q + WW'(1) : '0;
   assign timeout_d = timeout_q | expired;
   assign count_d   = retire ? count_q + COUNT_WIDTH'(1) : count_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end
   assign state_o       = state_q;
   assign pc_write_o    = (state_q == FETCH) | (state_q == JUMP) | ((state_q == BRANCH) & taken);
   assign ir_write_o    = (state_q == READ_MEM) & mem_ready_i;
   assign reg_write_o   = (state_q == ALU_WB) | (state_q == MEM_WB);
   assign mem_wr_ena_o  = (state_q == MEM_WRITE) & mem_ready_i;
   assign mem_req_o     = waiting;
   assign halted_o      = (state_q == HALT);
   assign timeout_o     = timeout_q;
   assign instr_count_o = count_q;
endmodule

// File: tb/tb_mips_main_fsm.sv
// tb_mips_main_fsm: randomized instruction streams against a per-instruction state-trace model
module tb_mips_main_fsm;
   logic        clk = 1'b0, rst = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic        zero = 1'b0, mem_ready = 1'b0;
   logic [3:0]  state;
   logic        pc_write, ir_write, reg_write, mem_wr_ena, mem_req, halted, timeout;
   logic [31:0] instr_count;
   int          errors = 0, checks = 0;
   int unsigned m_count = 0;
   int          q_st[$];
   bit          q_rdy[$], q_ret[$], q_tmo[$];

   always #5 clk = ~clk;

   mips_main_fsm dut (
      .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
      .mem_ready_i(mem_ready), .state_o(state), .pc_write_o(pc_write), .ir_write_o(ir_write),
      .reg_write_o(reg_write), .mem_wr_ena_o(mem_wr_ena), .mem_req_o(mem_req),
      .halted_o(halted), .timeout_o(timeout), .instr_count_o(instr_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int s, input bit r, input bit ret, input bit tmo);
      q_st.push_back(s); q_rdy.push_back(r); q_ret.push_back(ret); q_tmo.push_back(tmo);
   endtask

   // d not-ready cycles then one ready cycle; 15 or more not-ready cycles time out
   task automatic push_wait(input int s, input int d, input bit ret, output bit dead);
      dead = 0;
      for (int k = 0; k < ((d < 15) ? d : 15); k++) push(s, 0, 0, 0);
      if (d < 15) push(s, 1, ret, 0);
      else dead = 1;
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      m_count = 0;
      check("rst_state", state, 0);
      check("rst_pc_write", pc_write, 1);
      check("rst_halted", halted, 0);
      check("rst_timeout", timeout, 0);
      check("rst_count", instr_count, 0);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input bit z,
                            input int d0, input int d1);
      bit dead, stop, tk;
      int s;
      q_st.delete(); q_rdy.delete(); q_ret.delete(); q_tmo.delete();
      stop = 0;
      push(0, 1'($urandom), 0, 0);
      push_wait(1, d0, 0, dead);
      if (!dead) begin
         push(2, 1'($urandom), 0, 0);
         if (opc == 6'h00 && fn[5]) begin push(3, 1'($urandom), 0, 0); push(4, 1'($urandom), 1, 0); end
         else if (opc == 6'h08) begin push(11, 1'($urandom), 0, 0); push(4, 1'($urandom), 1, 0); end
         else if (opc == 6'h23) begin
            push(5, 1'($urandom), 0, 0);
            push_wait(6, d1, 0, dead);
            if (!dead) push(7, 1'($urandom), 1, 0);
         end else if (opc == 6'h2B) begin
            push(5, 1'($urandom), 0, 0);
            push_wait(8, d1, 1, dead);
         end else if (opc == 6'h04 || opc == 6'h05) push(9, 1'($urandom), 1, 0);
         else if (opc == 6'h02) push(10, 1'($urandom), 1, 0);
         else stop = 1;
      end
      if (dead || stop) for (int k = 0; k < 3; k++) push(15, 1'($urandom), 0, dead);
      for (int i = 0; i < q_st.size(); i++) begin
         opcode = opc; funct = fn; zero = z; mem_ready = q_rdy[i];
         #1;
         s  = q_st[i];
         tk = (opc == 6'h04) ? z : !z;
         check("state", state, s);
         check("pc_write", pc_write, (s == 0 || s == 10 || (s == 9 && tk)) ? 1 : 0);
         check("ir_write", ir_write, (s == 1 && q_rdy[i]) ? 1 : 0);
         check("reg_write", reg_write, (s == 4 || s == 7) ? 1 : 0);
         check("mem_wr_ena", mem_wr_ena, (s == 8 && q_rdy[i]) ? 1 : 0);
         check("mem_req", mem_req, (s == 1 || s == 6 || s == 8) ? 1 : 0);
         check("halted", halted, (s == 15) ? 1 : 0);
         check("timeout", timeout, q_tmo[i]);
         check("count", instr_count, m_count);
         if (q_ret[i]) m_count++;
         @(negedge clk);
      end
      if (dead || stop) async_reset();
   endtask

   initial begin
      logic [5:0] ops [9];
      logic [5:0] opc, fn;
      int d0, d1;
      ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h00};
      #1 rst = 1'b1;
      #1;
      check("init_state", state, 0);
      check("init_pc_write", pc_write, 1);
      check("init_count", instr_count, 0);
      check("init_timeout", timeout, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      run_instr(6'h00, 6'h20, 0, 0, 0);
      check("rtype_count", instr_count, 1);
      run_instr(6'h23, 6'h00, 0, 0, 3);
      run_instr(6'h2B, 6'h00, 0, 2, 1);
      run_instr(6'h04, 6'h00, 1, 0, 0);
      run_instr(6'h05, 6'h00, 1, 0, 0);
      run_instr(6'h02, 6'h00, 0, 1, 0);
      run_instr(6'h08, 6'h00, 0, 0, 0);
      run_instr(6'h00, 6'h1F, 0, 0, 0);
      run_instr(6'h3F, 6'h00, 0, 0, 0);
      run_instr(6'h00, 6'h20, 0, 15, 0);
      run_instr(6'h00, 6'h20, 0, 14, 0);
      run_instr(6'h23, 6'h00, 0, 0, 15);
      run_instr(6'h2B, 6'h00, 0, 0, 15);
      run_instr(6'h2B, 6'h00, 0, 0, 14);
      mem_ready = 1'b0;
      repeat (6) @(negedge clk);
      async_reset();
      run_instr(6'h00, 6'h20, 0, 14, 0);
      for (int n = 0; n < 200; n++) begin
         opc = ($urandom % 10 == 0) ? 6'($urandom) : ops[$urandom % 9];
         fn  = 6'($urandom) | (($urandom % 8 != 0) ? 6'h20 : 6'h00);
         d0  = ($urandom % 12 == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
         d1  = ($urandom % 12 == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
         run_instr(opc, fn, 1'($urandom), d0, d1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
